usb_crc16_tx: RTL and testbench

//  Transmit-side CRC16 generator/appender for the USB 2.0 serial interface engine.

---
 rtl/usb_crc16_tx.sv | 136 +++++++++++++
 tb/tb_usb_crc16_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc16_tx.sv
// USB 2.0 transmit CRC16 generator/appender: passes the LSB-first
// payload through and then appends the complemented CRC16, MSB first.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start, no_data     packet start pulse; no_data selects zero-length payload
//   din, din_valid,    payload bit, valid, and last-bit marker
//   din_last
//   din_ready          payload bit accepted when din_valid & din_ready
//   stream_out,        serial output bit and its valid flag
//   out_valid
//   out_ready          downstream takes stream_out (low = stall)
//   busy, done         packet in progress / last CRC bit taken pulse
//   crc_out            transmitted CRC (register ^ XOROUT)
module usb_crc16_tx #(
  parameter logic [15:0] POLY   = 16'h8005,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        no_data,
  input  logic        din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic        stream_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_FLUSH
  } state_t;

  state_t      r_state;
  logic [15:0] r_crc;
  logic [3:0]  r_cnt;

  logic        w_adv;
  logic        w_accept;
  logic        w_fb;
  logic [15:0] w_crc_step;
  logic [15:0] w_crc_tx;
  logic        w_crc_bit;

  // Output register is free, or its bit leaves this cycle.
  assign w_adv      = !out_valid || out_ready;
  assign din_ready  = (r_state == S_DATA) && w_adv;
  assign w_accept   = din_ready && din_valid;

  assign w_fb       = din ^ r_crc[15];
  assign w_crc_step = {r_crc[14:0], 1'b0}
                    ^ (w_fb ? POLY : 16'h0000);

  assign w_crc_tx   = r_crc ^ XOROUT;
  // 15 - cnt selects the CRC MSB first.
  assign w_crc_bit  = w_crc_tx[4'd15 - r_cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_crc      <= INIT;
      r_cnt      <= 4'd0;
      stream_out <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_out    <= 16'h0000;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_crc <= INIT;
            r_cnt <= 4'd0;
            busy  <= 1'b1;
            if (no_data) begin
              r_state <= S_CRC;
              crc_out <= INIT ^ XOROUT;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_adv) begin
            if (w_accept) begin
              stream_out <= din;
              out_valid  <= 1'b1;
              r_crc      <= w_crc_step;
              if (din_last) begin
                r_state <= S_CRC;
                r_cnt   <= 4'd0;
                // Capture the CRC including this final bit.
                crc_out <= w_crc_step ^ XOROUT;
              end
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        S_CRC: begin
          if (w_adv) begin
            stream_out <= w_crc_bit;
            out_valid  <= 1'b1;
            if (r_cnt == 4'd15) begin
              r_state <= S_FLUSH;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_crc16_tx.sv
// Self-checking bench for usb_crc16_tx.
// Reference: reflected (shift-right) CRC16 over bit queues.
module tb_usb_crc16_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        no_data = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        din_ready;
  logic        stream_out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [15:0] crc_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_at;

  bit pl[$];
  bit oq[$];
  int tq[$];
  int acc[$];
  bit ref2[$];
  logic [15:0] crc2;

  always #5 clk = ~clk;

  usb_crc16_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .no_data   (no_data),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .stream_out(stream_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .crc_out   (crc_out)
  );

  // A bit seen valid&ready here is taken at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      oq.push_back(stream_out);
      tq.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Mirror-image CRC: LSB-first register, reflected polynomial.
  function automatic logic [15:0] crc_model(input bit q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {15'd0, q[i]};
      if (c[0]) c = (c >> 1) ^ 16'hA001;
      else      c = c >> 1;
    end
    return rev16(c);
  endfunction

  task automatic run_pkt(input bit nd, input bit gap,
                         input int sp0, input int sp1,
                         input int xs, input int rst_at);
    int k;
    int n;
    int stall;
    int si;
    int sp[2];
    int sz;
    bit pulsed;
    n = nd ? 0 : pl.size();
    oq.delete(); tq.delete(); acc.delete();
    done_at = -1;
    sp[0] = sp0; sp[1] = sp1;
    si = 0; stall = 0; k = 0; pulsed = 0;
    start = 1; no_data = nd; out_ready = 1; din_valid = 0;
    @(posedge clk); #1;
    start = 0; no_data = 0;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 600; c++) begin
      if (done) begin
        done_at = c;
        break;
      end
      if (rst_at >= 0 && out_valid && oq.size() == rst_at) begin
        din_valid = 0; out_ready = 1; start = 0;
        #2 rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stream_out", stream_out, 0);
        chk("rst_din_ready", din_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        sz = oq.size();
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_emit", oq.size(), sz);
        chk("rst_idle_valid", out_valid, 0);
        return;
      end
      start = (xs >= 0 && k == xs && !pulsed);
      if (start) pulsed = 1;
      if (stall == 0 && si < 2 && out_valid && oq.size() == sp[si]) begin
        stall = 3;
        si++;
      end
      if (stall > 0) begin
        out_ready = 0;
        stall--;
      end else begin
        out_ready = 1;
      end
      din_valid = (k < n) && (!gap || (c % 2 == 0));
      din = (k < n) ? pl[k] : 1'b0;
      din_last = (k == n - 1);
      #1;
      if (din_valid && din_ready) begin
        acc.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
    end
    start = 0; din_valid = 0; din_last = 0; out_ready = 1;
    chk("done_seen", done_at >= 0, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic check_pkt(input bit timed);
    int n;
    logic [15:0] exp;
    n = pl.size();
    exp = ~crc_model(pl);
    chk("bit_count", oq.size(), n + 16);
    chk("crc_out", crc_out, exp);
    for (int i = 0; i < n; i++)
      if (i < oq.size()) chk("payload_bit", oq[i], pl[i]);
    for (int j = 0; j < 16; j++)
      if (n + j < oq.size()) chk("crc_bit", oq[n+j], exp[15-j]);
    chk("residual", crc_model(oq), 16'h800D);
    if (timed) begin
      for (int i = 0; i < n; i++)
        if (i < tq.size() && i < acc.size())
          chk("latency", tq[i], acc[i] + 1);
      for (int j = 1; j < 17; j++)
        if (n + j - 1 < tq.size() && n + j - 2 >= 0)
          chk("crc_no_gap", tq[n+j-1], tq[n+j-2] + 1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [15:0] w;
    int n;
    bit g;
    bit st;
    int s0;
    int s1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_din_ready", din_ready, 0);
    chk("reset_stream_out", stream_out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_crc_out", crc_out, 16'h0000);
    rst = 0;
    @(posedge clk); #1;

    // 1: zero-length packet
    pl.delete();
    run_pkt(1, 0, -1, -1, -1, -1);
    check_pkt(1);
    chk("nodata_done_lat", done_at, 17);
    chk("nodata_crc", crc_out, 16'h0000);

    // 2: bytes 00 01 02 03
    pl.delete();
    for (int i = 0; i < 4; i++) begin
      b = i[7:0];
      for (int j = 0; j < 8; j++) pl.push_back(b[j]);
    end
    run_pkt(0, 0, -1, -1, -1, -1);
    check_pkt(1);
    ref2 = oq;
    crc2 = crc_out;

    // 3: stalls at payload bit 5 and CRC bit 7
    run_pkt(0, 0, 5, 32 + 7, -1, -1);
    check_pkt(0);
    chk("stall_len_vs_ref", oq.size(), ref2.size());
    for (int i = 0; i < 48; i++)
      if (i < oq.size()) chk("stall_vs_ref", oq[i], ref2[i]);

    // 4: extra start at payload bit 10
    run_pkt(0, 0, -1, -1, 10, -1);
    check_pkt(1);
    chk("xstart_crc", crc_out, crc2);
    for (int i = 0; i < 48; i++)
      if (i < oq.size()) chk("xstart_vs_ref", oq[i], ref2[i]);

    // 5: reset during CRC bit 4, then fresh no_data packet
    run_pkt(0, 0, -1, -1, -1, 32 + 4);
    @(posedge clk); #1;
    pl.delete();
    run_pkt(1, 0, -1, -1, -1, -1);
    check_pkt(1);
    chk("post_rst_done_lat", done_at, 17);

    // 6: gapped input, 16'hA5C3
    pl.delete();
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) pl.push_back(w[i]);
    run_pkt(0, 1, -1, -1, -1, -1);
    check_pkt(1);

    // Random packets with random gaps and stalls
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(1'($urandom_range(0, 1)));
      g = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      s0 = st ? $urandom_range(0, n - 1) : -1;
      s1 = st ? n + $urandom_range(0, 15) : -1;
      run_pkt(0, g, s0, s1, -1, -1);
      check_pkt(!st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
